// File: rtl/led_pkg.sv
`default_nettype none
//==============================================================================
// Package  : led_pkg
// Desc     : Shared types and timing helpers for the multi-channel LED driver.
// Revision : 1.0 - initial release
//==============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_BURST = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_ON     = 3'd1,
        S_BL_ON  = 3'd2,
        S_BL_OFF = 3'd3,
        S_BU_ON  = 3'd4,
        S_BU_OFF = 3'd5
    } chan_state_e;

    localparam int unsigned C_DEFAULT_CLK_MHZ = 50;
    localparam int unsigned MS_CYCLES         = C_DEFAULT_CLK_MHZ * 1000;

    // Prescaler length for an arbitrary clock; MS_CYCLES is the default-clock value.
    function automatic int unsigned ms_cycles(input int unsigned clk_mhz);
        return clk_mhz * 1000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
//==============================================================================
// Module   : led_channel
// Desc     : One LED engine: OFF/ON/BLINK/BURST FSM with ms timer and flash count.
// Revision : 1.0 - initial release
//==============================================================================
module led_channel
    import led_pkg::*;
#(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned BURST_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_apply,
    input  mode_e               i_mode,
    input  logic [PERIOD_W-1:0] i_half_ms,
    input  logic [BURST_W-1:0]  i_count,
    input  logic                i_tick,
    output logic                o_led,
    output logic                o_busy
);

    chan_state_e         r_state,  w_state_nxt;
    logic [PERIOD_W-1:0] r_timer,  w_timer_nxt;
    logic [PERIOD_W-1:0] r_half,   w_half_nxt;
    logic [BURST_W-1:0]  r_remain, w_remain_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_OFF;
            r_timer  <= '0;
            r_half   <= '0;
            r_remain <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_half   <= w_half_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_half_nxt   = r_half;
        w_remain_nxt = r_remain;
        // A new config always restarts the channel; a coincident tick is dropped.
        if (i_apply) begin
            w_half_nxt   = (i_half_ms == '0) ? PERIOD_W'(1) : i_half_ms;
            w_timer_nxt  = '0;
            w_remain_nxt = '0;
            unique case (i_mode)
                LED_OFF:   w_state_nxt = S_OFF;
                LED_ON:    w_state_nxt = S_ON;
                LED_BLINK: begin
                    w_state_nxt = S_BL_ON;
                    w_timer_nxt = w_half_nxt;
                end
                LED_BURST: begin
                    if (i_count != '0) begin
                        w_state_nxt  = S_BU_ON;
                        w_timer_nxt  = w_half_nxt;
                        w_remain_nxt = i_count;
                    end else begin
                        w_state_nxt  = S_OFF;
                    end
                end
            endcase
        end else if (i_tick && (r_state inside {S_BL_ON, S_BL_OFF, S_BU_ON, S_BU_OFF})) begin
            if (r_timer > PERIOD_W'(1)) begin
                w_timer_nxt = r_timer - PERIOD_W'(1);
            end else begin
                w_timer_nxt = r_half;
                case (r_state)
                    S_BL_ON:  w_state_nxt = S_BL_OFF;
                    S_BL_OFF: w_state_nxt = S_BL_ON;
                    S_BU_ON:  w_state_nxt = S_BU_OFF;
                    S_BU_OFF: begin
                        if (r_remain <= BURST_W'(1)) begin
                            w_state_nxt  = S_OFF;
                            w_remain_nxt = '0;
                            w_timer_nxt  = '0;
                        end else begin
                            w_state_nxt  = S_BU_ON;
                            w_remain_nxt = r_remain - BURST_W'(1);
                        end
                    end
                    default: w_state_nxt = r_state;
                endcase
            end
        end
    end

    assign o_led  = (r_state == S_ON) || (r_state == S_BL_ON) || (r_state == S_BU_ON);
    assign o_busy = (r_state == S_BU_ON) || (r_state == S_BU_OFF);

endmodule
`default_nettype wire

// File: rtl/led_blinker_multi.sv
`default_nettype none
//==============================================================================
// Module   : led_blinker_multi
// Desc     : Shared 1 ms prescaler, config write port and CHANNELS LED engines.
// Revision : 1.0 - initial release
//==============================================================================
module led_blinker_multi
    import led_pkg::*;
#(
    parameter  int unsigned CLK_MHZ  = 50,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned PERIOD_W = 16,
    parameter  int unsigned BURST_W  = 4,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_half_ms,
    input  logic [BURST_W-1:0]  cfg_count,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] busy,
    output logic                ms_tick
);

    localparam int unsigned         c_ms_cycles = ms_cycles(CLK_MHZ);
    localparam int unsigned         c_pre_w     = $clog2(c_ms_cycles);
    localparam logic [c_pre_w-1:0]  c_pre_last  = c_pre_w'(c_ms_cycles - 1);
    localparam logic [CH_W:0]       c_chan_lim  = (CH_W + 1)'(CHANNELS);

    logic [c_pre_w-1:0]  r_presc;
    logic                r_ready;
    logic                r_apply;
    logic [CH_W-1:0]     r_chan;
    mode_e               r_mode;
    logic [PERIOD_W-1:0] r_half;
    logic [BURST_W-1:0]  r_count;

    logic w_tick;
    logic w_accept;
    logic w_chan_ok;

    assign w_tick    = (r_presc == c_pre_last);
    assign w_accept  = cfg_valid && r_ready;
    assign w_chan_ok = ({1'b0, cfg_chan} < c_chan_lim);

    // Writes to a non-existent channel complete the handshake but never reach an engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_ready <= 1'b0;
            r_apply <= 1'b0;
            r_chan  <= '0;
            r_mode  <= LED_OFF;
            r_half  <= '0;
            r_count <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_pre_w'(1);
            r_ready <= ~w_accept;
            r_apply <= w_accept && w_chan_ok;
            if (w_accept) begin
                r_chan  <= cfg_chan;
                r_mode  <= mode_e'(cfg_mode);
                r_half  <= cfg_half_ms;
                r_count <= cfg_count;
            end
        end
    end

    assign cfg_ready = r_ready;
    assign ms_tick   = w_tick;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            led_channel #(
                .PERIOD_W (PERIOD_W),
                .BURST_W  (BURST_W)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_apply   (r_apply && (r_chan == CH_W'(gi))),
                .i_mode    (r_mode),
                .i_half_ms (r_half),
                .i_count   (r_count),
                .i_tick    (w_tick),
                .o_led     (led[gi]),
                .o_busy    (busy[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_blinker_multi.sv
`default_nettype none
//==============================================================================
// Module   : tb_led_blinker_multi
// Desc     : Scoreboard bench for led_blinker_multi at CLK_MHZ=1, five channels.
// Revision : 1.0 - initial release
//==============================================================================
module tb_led_blinker_multi;
    import led_pkg::*;

    localparam int CH  = 5;
    localparam int CHW = 3;
    localparam int MS  = 1000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_chan;
    logic [1:0]     cfg_mode;
    logic [15:0]    cfg_half_ms;
    logic [3:0]     cfg_count;
    logic [CH-1:0]  led;
    logic [CH-1:0]  busy;
    logic           ms_tick;

    led_blinker_multi #(
        .CLK_MHZ  (1),
        .CHANNELS (CH),
        .PERIOD_W (16),
        .BURST_W  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_mode    (cfg_mode),
        .cfg_half_ms (cfg_half_ms),
        .cfg_count   (cfg_count),
        .led         (led),
        .busy        (busy),
        .ms_tick     (ms_tick)
    );

    always #5 clk = ~clk;

    typedef struct { int t; logic l; logic b; } ev_t;
    ev_t sb[$];

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            mc       = 0;
    logic [CH-1:0] exp_led;
    logic [CH-1:0] exp_busy;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference millisecond counter, reset together with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mc <= 0;
        else        mc <= (mc == MS - 1) ? 0 : mc + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_led = '0;
        exp_busy = '0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic drive_cfg(input int ch, input logic [1:0] mode, input int half, input int cnt);
        cfg_valid   = 1'b1;
        cfg_chan    = CHW'(ch);
        cfg_mode    = mode;
        cfg_half_ms = 16'(half);
        cfg_count   = 4'(cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan = '0;
        cfg_mode = '0;
        cfg_half_ms = '0;
        cfg_count = '0;
        #12 rst_n = 1'b0;
        #1;
        checks += 4;
        if (led !== '0)       begin failures++; $display("FAIL reset_led: led=%b, required 0", led); end
        if (busy !== '0)      begin failures++; $display("FAIL reset_busy: busy=%b, required 0", busy); end
        if (cfg_ready !== 0)  begin failures++; $display("FAIL reset_ready: cfg_ready=%b, required 0", cfg_ready); end
        if (ms_tick !== 0)    begin failures++; $display("FAIL reset_tick: ms_tick=%b, required 0", ms_tick); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 0) begin failures++; $display("FAIL reset_ready_pre_edge: cfg_ready=%b, required 0", cfg_ready); end
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1) begin failures++; $display("FAIL reset_ready_post_edge: cfg_ready=%b, required 1", cfg_ready); end
        exp_led = '0;
        exp_busy = '0;
    endtask

    task automatic test_prescaler();
        do_reset();
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            checks++;
            if (ms_tick !== (mc == MS - 1)) begin
                failures++;
                $display("FAIL prescaler_tick: cyc=%0d ms_tick=%b, required %b", cyc, ms_tick, (mc == MS - 1));
            end
        end
    endtask

    task automatic test_handshake();
        logic rq[$];
        logic exp_r;
        int   k;
        do_reset();
        k = 0;
        for (int i = 0; i < 8; i++) rq.push_back(i % 2 == 1);
        drive_cfg(0, LED_ON, 1, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_r = rq.pop_front();
            checks++;
            if (cfg_ready !== exp_r) begin
                failures++;
                $display("FAIL handshake_ready: edge %0d cfg_ready=%b, required %b", i + 1, cfg_ready, exp_r);
            end
            if (!exp_r) begin
                k++;
                cfg_chan = CHW'(k);
            end
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (led !== 5'b01111 || busy !== '0) begin
            failures++;
            $display("FAIL handshake_leds: led=%b busy=%b, required led=01111 busy=00000", led, busy);
        end
        drive_cfg(5, LED_ON, 1, 0);
        @(negedge clk);
        checks++;
        if (cfg_ready !== 0) begin failures++; $display("FAIL badchan_accept: cfg_ready=%b, required 0", cfg_ready); end
        cfg_chan = 3'd7;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cfg_ready !== 0) begin failures++; $display("FAIL badchan7_accept: cfg_ready=%b, required 0", cfg_ready); end
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 5'b01111 || busy !== '0 || cfg_ready !== 1) begin
            failures++;
            $display("FAIL badchan_ignored: led=%b busy=%b ready=%b, required led=01111 busy=00000 ready=1", led, busy, cfg_ready);
        end
        exp_led = 5'b01111;
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== '0 || busy !== '0 || cfg_ready !== 0 || ms_tick !== 0) begin
            failures++;
            $display("FAIL midreset_async: led=%b busy=%b ready=%b tick=%b, required all 0", led, busy, cfg_ready, ms_tick);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (led !== '0 || cfg_ready !== 1) begin
            failures++;
            $display("FAIL midreset_release: led=%b ready=%b, required led=00000 ready=1", led, cfg_ready);
        end
        exp_led = '0;
        exp_busy = '0;
    endtask

    // One write, expected LED/busy edges queued from the timing model, then scored as they appear.
    task automatic test_sequence(input string name, input int ch, input logic [1:0] mode,
                                 input int half, input int cnt, input int q_acc, input int ncyc);
        int   c0, q, d, h, t, a, e_end, waited;
        logic l, b, pl, pb, do_toggle;
        ev_t  ev;
        waited = 0;
        if (q_acc >= 0) begin
            while (mc != q_acc && waited < 2 * MS) begin
                @(negedge clk);
                waited++;
            end
            if (mc != q_acc) begin
                checks++;
                failures++;
                $display("FAIL %s phase_wait: timed out at phase %0d, required %0d", name, mc, q_acc);
            end
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before_write: cfg_ready=%b, required 1", name, cfg_ready);
        end
        c0 = cyc;
        q = (mc + 1) % MS;
        a = c0 + 2;
        e_end = c0 + ncyc;
        drive_cfg(ch, mode, half, cnt);
        h = (half == 0) ? 1 : half;
        d = (q == MS - 1) ? MS : MS - 1 - q;
        b = (mode == LED_BURST) && (cnt != 0);
        l = (mode == LED_ON) || (mode == LED_BLINK) || b;
        do_toggle = (mode == LED_BLINK) || b;
        if (l !== exp_led[ch] || b !== exp_busy[ch]) sb.push_back(ev_t'{a, l, b});
        if (do_toggle) begin
            for (int n = 1; n <= 64; n++) begin
                t = a + d + (n * h - 1) * MS;
                if (t > e_end) break;
                l = (n % 2 == 0);
                if (b && n == 2 * cnt) begin
                    l = 1'b0;
                    b = 1'b0;
                end
                sb.push_back(ev_t'{t, l, b});
                if (mode == LED_BURST && !b) break;
            end
        end
        exp_led[ch] = l;
        exp_busy[ch] = b;
        pl = led[ch];
        pb = busy[ch];
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (i == 1) cfg_valid = 1'b0;
            if (led[ch] !== pl || busy[ch] !== pb) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_change: cyc=%0d led=%b busy=%b, required no change", name, cyc, led[ch], busy[ch]);
                end else begin
                    ev = sb.pop_front();
                    if (cyc != ev.t || led[ch] !== ev.l || busy[ch] !== ev.b) begin
                        failures++;
                        $display("FAIL %s event: cyc=%0d led=%b busy=%b, required cyc=%0d led=%b busy=%b",
                                 name, cyc, led[ch], busy[ch], ev.t, ev.l, ev.b);
                    end
                end
                pl = led[ch];
                pb = busy[ch];
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s missing_events: %0d not seen, first required at cyc=%0d", name, sb.size(), sb[0].t);
        end
        checks++;
        if (led !== exp_led || busy !== exp_busy) begin
            failures++;
            $display("FAIL %s final_state: led=%b busy=%b, required led=%b busy=%b", name, led, busy, exp_led, exp_busy);
        end
        sb.delete();
    endtask

    task automatic test_blink();
        do_reset();
        test_sequence("blink", 1, LED_BLINK, 3, 0, 500, 11000);
    endtask

    task automatic test_burst();
        do_reset();
        test_sequence("burst", 0, LED_BURST, 2, 3, 200, 14000);
    endtask

    task automatic test_abort();
        do_reset();
        test_sequence("abort_burst", 2, LED_BURST, 2, 5, 0, 5500);
        test_sequence("abort_on", 2, LED_ON, 2, 0, -1, 3000);
    endtask

    task automatic test_corner();
        do_reset();
        test_sequence("half0_blink", 0, LED_BLINK, 0, 0, 300, 4500);
        do_reset();
        test_sequence("count0_burst", 1, LED_BURST, 5, 0, 100, 3000);
        do_reset();
        test_sequence("apply_on_tick", 2, LED_BLINK, 2, 0, MS - 2, 5200);
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_handshake();
        test_reset_mid();
        test_blink();
        test_burst();
        test_abort();
        test_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/led_blinker_multi.md
Name: led_blinker_multi

Overview:
- Multi-channel LED driver; the parametrised successor of the single free-running board blinker.
- One shared 1 ms prescaler, derived from CLK_MHZ, feeds CHANNELS independent per-channel engines.
- Per-channel modes: OFF, ON, BLINK (programmable half-period), BURST (N flashes, then auto-off).
- A config write port lets the core or a debug UART select mode and timing at runtime; sits at top level next to the status LEDs.

Parameters:
- CLK_MHZ, 50, input clock in MHz; the prescaler wraps every CLK_MHZ*1000 cycles.
- CHANNELS, 4, number of LED outputs; legal range 1..16.
- PERIOD_W, 16, width of the half-period field, in ms.
- BURST_W, 4, width of the burst flash count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config port can accept a write
- cfg_chan  in  CH_W  target channel; CH_W = max(1, $clog2(CHANNELS))
- cfg_mode  in  2  0 OFF, 1 ON, 2 BLINK, 3 BURST
- cfg_half_ms  in  PERIOD_W  on-time and off-time, in ms
- cfg_count  in  BURST_W  number of flashes in BURST mode
- led  out  CHANNELS  LED drive, active-high
- busy  out  CHANNELS  1 while the channel's burst is in progress
- ms_tick  out  1  one-cycle pulse every 1 ms

Behaviour:
- Reset (async, rst_n=0), all outputs forced immediately:
  - led=0, busy=0, ms_tick=0, cfg_ready=0.
  - Prescaler=0; every channel in S_OFF with its timer at 0.
  - cfg_ready rises on the first clk edge after rst_n deasserts.
- Prescaler:
  - Counts 0..CLK_MHZ*1000-1 and wraps.
  - ms_tick=1 in the cycle the count equals the terminal value.
  - Free-running; config writes never affect it.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready at a clk edge; fields are captured into a one-entry apply register.
  - cfg_ready=0 in the cycle after an accept, then returns to 1. Maximum rate is one write per 2 cycles.
  - The captured config is applied to the target channel on the edge following the accept.
  - led shows the new mode in the cycle after apply, i.e. 2 edges after the accept edge.
  - cfg_chan >= CHANNELS: the write is accepted and then discarded; no channel changes.
- Per-channel FSM, states S_OFF, S_ON, S_BL_ON, S_BL_OFF, S_BU_ON, S_BU_OFF:
  - OFF -> S_OFF, led=0.
  - ON -> S_ON, led=1.
  - BLINK -> S_BL_ON, led=1, timer=half_ms.
  - BURST -> S_BU_ON, led=1, busy=1, remaining=count, timer=half_ms.
- Timer:
  - Decrements only on ms_tick.
  - When it reaches 0 in a blink/burst state, the FSM toggles phase and reloads timer=half_ms.
- BLINK: S_BL_ON <-> S_BL_OFF indefinitely. The period is 2*half_ms ms, accurate to within 1 ms on the first phase.
- BURST:
  - On the S_BU_OFF -> next transition, remaining decrements.
  - If remaining would reach 0, go to S_OFF and drop busy in the same cycle as the transition; otherwise go to S_BU_ON.
- Arithmetic and boundary rules:
  - half_ms=0 is treated as 1.
  - BURST with count=0 behaves as OFF; busy never asserts.
  - Timer and remaining counters never underflow.
- Simultaneous apply and ms_tick on the same channel: apply wins. The timer loads half_ms and that tick is ignored for that channel.
- Reconfiguration mid-blink or mid-burst: the current sequence is aborted and the new mode starts from its initial state. busy follows the new mode.
- Reset mid-operation: everything returns to the reset state asynchronously; no partial burst resumes.
- Channels are fully independent; all channels see the same ms_tick.

Decomposition:
- Package led_pkg holds:
  - mode_e: LED_OFF=2'd0, LED_ON=2'd1, LED_BLINK=2'd2, LED_BURST=2'd3.
  - chan_state_e: the six FSM states.
  - localparam MS_CYCLES = CLK_MHZ*1000.
- Sub-module led_channel holds the FSM, timer, remaining counter and led/busy outputs; it is instantiated CHANNELS times via generate.
- The top level holds the prescaler, the config handshake and the apply register.

Test Plan (all scenarios use CLK_MHZ=1, so 1 ms = 1000 cycles):
1. Reset: hold rst_n=0 mid-simulation while led=4'b1111 -> led=0, busy=0 asynchronously; after release, cfg_ready=1 on the next edge.
2. BLINK: write chan 1, mode 2, half_ms=3 -> led[1]=1 two edges after accept, then toggles every 3 ms (±1 ms on the first phase); other channels remain 0.
3. BURST: write chan 0, mode 3, half_ms=2, count=3 -> exactly 3 high pulses of 2 ms on led[0]; busy[0] falls together with the final off-phase end; the channel then stays off.
4. Handshake: hold cfg_valid=1 with back-to-back writes to chans 0..3 mode ON -> cfg_ready alternates 1/0, 4 accepts in 8 cycles, led=4'b1111; a write with cfg_chan=5 (CHANNELS=4) changes nothing.
5. Abort: mid-burst on chan 2 (count=5), write mode ON -> busy[2]=0 and led[2]=1 steadily from the apply cycle on.
6. Corner values: half_ms=0 in BLINK -> toggles every 1 ms; BURST with count=0 -> led=0, busy never asserts; apply coinciding with ms_tick -> the first phase lasts the full half_ms.
